// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder.
//   state_t  : control FSM states (IDLE / RUN / DONE)
//   NIBBLE_W : slice width, fixed at 4 bits
//   clog2()  : counter width for the nibble index
package cla_nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= n. Callers pass n >= 2, so the result is at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
//   a4, b4 : nibble operands
//   ci     : carry into bit 0
//   s4     : nibble sum
//   co     : carry out of bit 3
//   c3     : carry into bit 3 (used for signed overflow on the MSB nibble)
module cla4_slice
    import cla_nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co,
    output logic                c3
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a4 & b4;
    assign w_p = a4 ^ b4;

    // Every carry is a flat sum of products of g/p and ci: no ripple inside the slice.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s4 = w_p ^ w_c[3:0];
    assign co = w_c[4];
    assign c3 = w_c[3];

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit CLA slice is reused for NIBBLES cycles.
// The carry between nibbles passes only through r_carry.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf), all registered
// Only one transaction is in flight. The result is held in DONE until taken.
module cla_nibble_serial_adder
    import cla_nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = clog2(NIBBLES);

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic [CW-1:0]       r_cnt;

    logic                w_last;
    logic [NIBBLE_W-1:0] w_a4;
    logic [NIBBLE_W-1:0] w_b4;
    logic [NIBBLE_W-1:0] w_s4;
    logic                w_co;
    logic                w_c3;

    assign w_last = (r_cnt == CW'(NIBBLES - 1));
    assign w_a4   = r_a[int'(r_cnt) * NIBBLE_W +: NIBBLE_W];
    assign w_b4   = r_b[int'(r_cnt) * NIBBLE_W +: NIBBLE_W];

    cla4_slice u_slice (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co),
        .c3 (w_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[int'(r_cnt) * NIBBLE_W +: NIBBLE_W] <= w_s4;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_cout <= w_co;
                        // Overflow: carry into the MSB differs from carry out of it.
                        r_ovf  <= w_co ^ w_c3;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
module tb_cla_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic [3:0]  sa, sb, ss;
    logic        sci, sco, sc3;

    int tests  = 0;
    int fails  = 0;
    int n_in   = 0;
    int n_out  = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    cla4_slice u_slice (
        .a4 (sa),
        .b4 (sb),
        .ci (sci),
        .s4 (ss),
        .co (sco),
        .c3 (sc3)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)   n_in  = n_in + 1;
            if (out_valid && out_ready) n_out = n_out + 1;
        end
    end

    // Drives one transaction; starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                           input int idle, input int rdly,
                           output logic [15:0] rs, output logic rco, output logic rov,
                           output int lat, output bit acc);
        int w;
        in_valid = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        a = ta; b = tbv; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        acc = !in_ready;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        repeat (rdly) begin @(posedge clk); #1; end
        rs = sum; rco = cout; rov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_slice();
        logic [4:0] e;
        logic [3:0] lo;
        logic [8:0] v;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            sa = v[8:5]; sb = v[4:1]; sci = v[0];
            #1;
            e  = 5'(sa) + 5'(sb) + 5'(sci);
            lo = 4'(sa[2:0]) + 4'(sb[2:0]) + 4'(sci);
            tests++;
            if (ss !== e[3:0] || sco !== e[4] || sc3 !== lo[3]) begin
                fails++;
                $display("FAIL slice a=%h b=%h ci=%b: got s=%h co=%b c3=%b, want s=%h co=%b c3=%b",
                         sa, sb, sci, ss, sco, sc3, e[3:0], e[4], lo[3]);
            end
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h1234};
        logic [15:0] vb [4] = '{16'h0000, 16'h0001, 16'h0001, 16'h4321};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [4] = '{16'h0000, 16'h0000, 16'h8000, 16'h5556};
        logic        eco[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        eov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] rs; logic rco, rov; int lat; bit acc;
        for (int i = 0; i < 4; i++) begin
            run_txn(va[i], vb[i], vc[i], 0, 0, rs, rco, rov, lat, acc);
            tests++;
            if (rs !== es[i] || rco !== eco[i] || rov !== eov[i]) begin
                fails++;
                $display("FAIL directed_%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, rs, rco, rov, es[i], eco[i], eov[i]);
            end
            tests++;
            if (lat !== 4 || !acc) begin
                fails++;
                $display("FAIL latency_%0d: got %0d cycles accepted=%0d, want 4 cycles accepted=1", i, lat, acc);
            end
        end
    endtask

    task automatic test_out_ready_idle();
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h5556) begin
            fails++;
            $display("FAIL out_ready_idle: in_ready=%b out_valid=%b sum=%h, want 1 0 5556", in_ready, out_valid, sum);
        end
    endtask

    task automatic test_backpressure();
        int w, base_in, base_out;
        base_in = n_in; base_out = n_out;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b1) begin
                fails++;
                $display("FAIL backpressure_%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b, want 1 0 0000 1 1",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        tests++;
        if (n_in - base_in !== 1 || n_out - base_out !== 1) begin
            fails++;
            $display("FAIL backpressure_handshakes: in=%0d out=%0d, want 1 1", n_in - base_in, n_out - base_out);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] rs; logic rco, rov; int lat; bit acc;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000) begin
            fails++;
            $display("FAIL reset_abort: in_ready=%b out_valid=%b sum=%h, want 1 0 0000", in_ready, out_valid, sum);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort_noresult: out_valid=%b, want 0", out_valid);
        end
        run_txn(16'h00FF, 16'h0001, 1'b0, 0, 0, rs, rco, rov, lat, acc);
        tests++;
        if (rs !== 16'h0100 || rco !== 1'b0 || rov !== 1'b0 || lat !== 4 || !acc) begin
            fails++;
            $display("FAIL after_reset_txn: sum=%h cout=%b ovf=%b lat=%0d acc=%0d, want 0100 0 0 4 1",
                     rs, rco, rov, lat, acc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta, tbv, rs; logic tc, rco, rov; logic [16:0] e; logic eov;
        int lat; bit acc; int bad, base_in, base_out;
        bad = 0; base_in = n_in; base_out = n_out;
        for (int i = 0; i < 500; i++) begin
            ta = 16'($urandom); tbv = 16'($urandom); tc = 1'($urandom);
            if (i % 5 == 0) begin ta[15] = tbv[15]; end
            run_txn(ta, tbv, tc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rs, rco, rov, lat, acc);
            e   = 17'(ta) + 17'(tbv) + 17'(tc);
            eov = (ta[15] == tbv[15]) && (e[15] != ta[15]);
            tests++;
            if (rs !== e[15:0] || rco !== e[16] || rov !== eov || lat !== 4) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_%0d %h+%h+%b: got %h/%b/%b lat=%0d, want %h/%b/%b lat=4",
                             i, ta, tbv, tc, rs, rco, rov, lat, e[15:0], e[16], eov);
                bad++;
            end
        end
        tests++;
        if (n_in - base_in !== 500 || n_out - base_out !== 500) begin
            fails++;
            $display("FAIL random_counts: in=%0d out=%0d, want 500 500", n_in - base_in, n_out - base_out);
        end
    endtask

    initial begin
        test_reset();
        test_slice();
        test_directed();
        test_out_ready_idle();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_nibble_serial_adder.md
CLA_NIBBLE_SERIAL_ADDER -- requirements
Module: cla_nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand transaction offered.
REQ-005 in_ready  output  1  block can accept an operand transaction.
REQ-006 a  input  W  operand A, unsigned/two's-complement.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in to nibble 0.
REQ-009 out_valid  output  1  result transaction offered.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 sum  output  W  (a + b + cin) mod 2^W.
REQ-012 cout  output  1  carry out of the MSB nibble.
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 FSM states IDLE, RUN, DONE; only one transaction in flight.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch a, b, and cin as carry, clear nibble counter, go to RUN.
REQ-016 RUN: each cycle, the 4-bit CLA slice adds nibble[cnt] of A and B plus the registered carry; result written to sum[4*cnt+3:4*cnt]; carry register updated with the slice carry-out; cnt increments.
REQ-017 RUN: when cnt reaches NIBBLES-1, the final nibble is written, cout and ovf are registered, and the FSM goes to DONE.
REQ-018 Latency: accept at edge k gives out_valid=1 after edge k+NIBBLES (4 cycles at default).
REQ-019 DONE: out_valid=1; sum/cout/ovf are held stable until out_valid&&out_ready, then the FSM returns to IDLE on that edge.
REQ-020 in_ready=0 in RUN and DONE; in_valid is ignored there, and operands changing after acceptance have no effect.
REQ-021 No same-cycle accept in DONE; minimum initiation interval is NIBBLES+2 cycles.
REQ-022 sum/cout/ovf are registered outputs; no combinational path from a/b/cin to outputs.
REQ-023 Carry ripples between nibbles only through the carry register; within a nibble, generate/propagate lookahead is used (no ripple).
REQ-024 out_ready asserted outside DONE has no effect.

Reset
REQ-025 On rst_n=0: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, cnt=0, carry=0, latched operands=0, applied immediately and independent of clk.
REQ-026 Reset during RUN or DONE aborts the transaction; no result is delivered for it.
REQ-027 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package holds the state enum (IDLE/RUN/DONE), NIBBLE_W=4, and the counter-width function clog2(NIBBLES).
REQ-029 One sub-module, cla4_slice: combinational 4-bit CLA (a4, b4, ci -> s4, co, c3 carry into bit 3) instantiated once and reused every RUN cycle.
REQ-030 cla4_slice is also verified standalone, exhaustively (512 vectors).

Verification
REQ-031 a=0x0000, b=0x0000, cin=0 accepted at edge 0 -> out_valid after edge 4, sum=0x0000, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all nibble boundaries).
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> sum/cout/ovf/out_valid stable; in_ready=0 throughout; in_valid pulses are not accepted.
REQ-035 rst_n pulsed low after 2 RUN cycles -> next sampled in_ready=1, out_valid=0, sum=0; new transaction 0x00FF+0x0001 -> 0x0100.
REQ-036 Scoreboard: 500 random (a, b, cin) with random in_valid/out_ready gaps -> every result matches a behavioural W+1-bit add; transaction count in equals count out.
